sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller between two access ports and the refresh engine.
- Port A is the Zorro III bus slave path; port B is a secondary master (DMA/local CPU).
- The block sequences each controller operation with a start/done handshake.
- Generates refresh requests internally, allows postponing them during bursts of traffic, and forces them before the postpone budget runs out.

---
 rtl/sdram_pkg.sv | 20 ++
 rtl/refresh_budget.sv | 55 +++++
 rtl/sdram_arbiter.sv | 120 ++++++++++++
 tb/tb_sdram_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared encodings and default timing for the SDRAM arbiter and controller.
// Imported by the arbiter top and its refresh budget counter.
package sdram_pkg;

    localparam logic [1:0] SEL_PORT_A  = 2'b00;
    localparam logic [1:0] SEL_PORT_B  = 2'b01;
    localparam logic [1:0] SEL_REFRESH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_RELEASE
    } arb_state_t;

    localparam int REFRESH_INTERVAL = 390;
    localparam int T_RP             = 3;
    localparam int T_RFC            = 7;

endpackage

// File: rtl/refresh_budget.sv
// Refresh tick generator with a saturating count of owed refreshes
// and a sticky flag for ticks lost at the postpone limit.
module refresh_budget
    import sdram_pkg::*;
#(
    parameter int INTERVAL     = sdram_pkg::REFRESH_INTERVAL,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       dec,
    output logic [3:0] pending,
    output logic       force_refresh,
    output logic       overflow
);

    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);
    localparam logic [3:0] MAXP = 4'(MAX_POSTPONE);

    if (MAX_POSTPONE < 1 || MAX_POSTPONE > 15) begin : g_bad_postpone
        $error("MAX_POSTPONE must be within 1..15");
    end

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick          = (cnt == LAST);
    assign force_refresh = (pending == MAXP);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // A tick that coincides with a completed refresh cancels out.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (tick && !dec) begin
            if (pending == MAXP) begin
                overflow <= 1'b1;
            end else begin
                pending <= pending + 1'b1;
            end
        end else if (dec && !tick && pending != '0) begin
            pending <= pending - 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between port A, port B and refresh,
// sequencing each operation with a start/done handshake.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = sdram_pkg::REFRESH_INTERVAL,
    parameter int MAX_POSTPONE     = 8,
    parameter int FAIR_LIMIT       = 4
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       init_done,
    input  logic       a_req,
    output logic       a_gnt,
    input  logic       b_req,
    output logic       b_gnt,
    output logic       ctl_start,
    output logic [1:0] ctl_sel,
    input  logic       ctl_done,
    output logic [3:0] refresh_pending,
    output logic       refresh_overflow
);

    localparam int SW = $clog2(FAIR_LIMIT + 1);
    localparam logic [SW-1:0] FAIR = SW'(FAIR_LIMIT);

    arb_state_t    state_q, state_d;
    logic          a_gnt_d, b_gnt_d;
    logic [1:0]    sel_d;
    logic [SW-1:0] streak, streak_d;
    logic          force_refresh;
    logic          dec;

    assign dec = (state_q == ST_BUSY) && ctl_done
               && (ctl_sel == SEL_REFRESH);

    refresh_budget #(
        .INTERVAL     (REFRESH_INTERVAL),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) u_budget (
        .CLK           (CLK),
        .RESET_n       (RESET_n),
        .dec           (dec),
        .pending       (refresh_pending),
        .force_refresh (force_refresh),
        .overflow      (refresh_overflow)
    );

    assign ctl_start = (state_q == ST_ISSUE);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= ST_IDLE;
            a_gnt   <= 1'b0;
            b_gnt   <= 1'b0;
            ctl_sel <= SEL_PORT_A;
            streak  <= '0;
        end else begin
            state_q <= state_d;
            a_gnt   <= a_gnt_d;
            b_gnt   <= b_gnt_d;
            ctl_sel <= sel_d;
            streak  <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_gnt_d  = a_gnt;
        b_gnt_d  = b_gnt;
        sel_d    = ctl_sel;
        streak_d = streak;
        unique case (state_q)
            ST_IDLE: begin
                if (init_done) begin
                    if (force_refresh) begin
                        state_d = ST_ISSUE;
                        sel_d   = SEL_REFRESH;
                    end else if (a_req && b_req && streak == FAIR) begin
                        state_d  = ST_ISSUE;
                        sel_d    = SEL_PORT_B;
                        b_gnt_d  = 1'b1;
                        streak_d = '0;
                    end else if (a_req) begin
                        // Rule above caps the streak, so +1 cannot pass FAIR.
                        state_d  = ST_ISSUE;
                        sel_d    = SEL_PORT_A;
                        a_gnt_d  = 1'b1;
                        streak_d = b_req ? streak + 1'b1 : '0;
                    end else if (b_req) begin
                        state_d  = ST_ISSUE;
                        sel_d    = SEL_PORT_B;
                        b_gnt_d  = 1'b1;
                        streak_d = '0;
                    end else if (refresh_pending != '0) begin
                        state_d = ST_ISSUE;
                        sel_d   = SEL_REFRESH;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (ctl_done) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                a_gnt_d = 1'b0;
                b_gnt_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected grant owners are queued
// by the stimulus and popped on every ctl_start by a monitor.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic       init_done;
    logic       a_req, b_req;
    logic       a_gnt, b_gnt;
    logic       ctl_start;
    logic [1:0] ctl_sel;
    logic       ctl_done;
    logic [3:0] refresh_pending;
    logic       refresh_overflow;

    logic       m_done;
    logic       s_done;
    bit         auto_done;
    int         done_cnt;

    int         vectors = 0;
    int         errs = 0;
    logic [1:0] exp_q[$];
    logic [1:0] e;

    assign ctl_done = m_done | s_done;

    always #5 CLK = ~CLK;

    sdram_arbiter dut (
        .CLK              (CLK),
        .RESET_n          (RESET_n),
        .init_done        (init_done),
        .a_req            (a_req),
        .a_gnt            (a_gnt),
        .b_req            (b_req),
        .b_gnt            (b_gnt),
        .ctl_start        (ctl_start),
        .ctl_sel          (ctl_sel),
        .ctl_done         (ctl_done),
        .refresh_pending  (refresh_pending),
        .refresh_overflow (refresh_overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic a, input logic b);
        @(posedge CLK);
        #1;
        RESET_n = 1'b0;
        a_req   = 1'b0;
        b_req   = 1'b0;
        s_done  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        init_done = 1'b1;
        a_req     = a;
        b_req     = b;
        @(negedge CLK);
        RESET_n = 1'b1;
    endtask

    // Controller model: done pulse five cycles after each start.
    initial begin
        m_done   = 1'b0;
        done_cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            m_done = 1'b0;
            if (!RESET_n) begin
                done_cnt = 0;
            end else if (ctl_start) begin
                done_cnt = auto_done ? 5 : 0;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) m_done = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET_n === 1'b1 && ctl_start === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL sb_unexpected: start sel=%b, required none",
                         ctl_sel);
            end else begin
                e = exp_q.pop_front();
                if (ctl_sel !== e || a_gnt !== (e == SEL_PORT_A)
                    || b_gnt !== (e == SEL_PORT_B)) begin
                    errs++;
                    $display("FAIL sb_grant: sel=%b a=%b b=%b, required sel=%b",
                             ctl_sel, a_gnt, b_gnt, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        bit found;

        RESET_n   = 1'b0;
        init_done = 1'b0;
        a_req     = 1'b0;
        b_req     = 1'b0;
        s_done    = 1'b0;
        auto_done = 1'b1;
        #12;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_start", ctl_start, 0);
        chk("rst_sel", ctl_sel, 0);
        chk("rst_pending", refresh_pending, 0);
        chk("rst_overflow", refresh_overflow, 0);

        // Idle: first tick at cycle 390, refresh issued one cycle later.
        do_reset(1'b0, 1'b0);
        exp_q.push_back(SEL_REFRESH);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge CLK);
            #1;
            if (refresh_pending != 0) begin
                n = i;
                break;
            end
        end
        chk("tick_cycle", n, 390);
        chk("no_start_at_tick", ctl_start, 0);
        @(posedge CLK);
        #1;
        chk("refresh_start", ctl_start, 1);
        chk("refresh_sel", ctl_sel, 2);
        repeat (10) @(posedge CLK);
        #1;
        chk("idle_pending_drained", refresh_pending, 0);
        chk("idle_queue_empty", exp_q.size(), 0);

        // a_req held: 390 A ops of 8 cycles, then forced refresh.
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 390; i++) exp_q.push_back(SEL_PORT_A);
        exp_q.push_back(SEL_REFRESH);
        found = 1'b0;
        for (int i = 0; i < 3300; i++) begin
            @(posedge CLK);
            #1;
            if (ctl_start && ctl_sel == SEL_REFRESH) begin
                found = 1'b1;
                break;
            end
        end
        chk("force_seen", found, 1);
        chk("force_pending", refresh_pending, 8);
        a_req = 1'b0;
        for (int i = 0; i < 7; i++) exp_q.push_back(SEL_REFRESH);
        repeat (80) @(posedge CLK);
        #1;
        chk("force_drained", refresh_pending, 0);
        chk("force_no_ovf", refresh_overflow, 0);
        chk("force_queue_empty", exp_q.size(), 0);

        // Both ports held: fairness gives B every fifth grant.
        do_reset(1'b1, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(SEL_PORT_A);
            exp_q.push_back(SEL_PORT_B);
        end
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            #1;
            if (ctl_start) cnt++;
            if (cnt == 10) break;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("fair_starts", cnt, 10);
        repeat (20) @(posedge CLK);
        #1;
        chk("fair_queue_empty", exp_q.size(), 0);

        // Done withheld: pending saturates, tick 3510 overflows.
        auto_done = 1'b0;
        do_reset(1'b0, 1'b0);
        exp_q.push_back(SEL_REFRESH);
        repeat (3509) @(posedge CLK);
        #1;
        chk("sat_pending", refresh_pending, 8);
        chk("sat_no_ovf", refresh_overflow, 0);
        @(posedge CLK);
        #1;
        chk("ovf_set", refresh_overflow, 1);
        chk("ovf_pending", refresh_pending, 8);
        auto_done = 1'b1;
        s_done    = 1'b1;
        @(posedge CLK);
        #1;
        s_done = 1'b0;
        for (int i = 0; i < 7; i++) exp_q.push_back(SEL_REFRESH);
        repeat (80) @(posedge CLK);
        #1;
        chk("ovf_sticky", refresh_overflow, 1);
        chk("ovf_drained", refresh_pending, 0);
        chk("ovf_queue_empty", exp_q.size(), 0);

        // Tick and refresh done on the same edge with pending 3.
        auto_done = 1'b0;
        do_reset(1'b0, 1'b0);
        chk("ovf_cleared", refresh_overflow, 0);
        exp_q.push_back(SEL_REFRESH);
        repeat (1559) @(posedge CLK);
        #1;
        chk("same_pre", refresh_pending, 3);
        auto_done = 1'b1;
        s_done    = 1'b1;
        @(posedge CLK);
        #1;
        s_done = 1'b0;
        chk("same_edge", refresh_pending, 3);
        for (int i = 0; i < 3; i++) exp_q.push_back(SEL_REFRESH);
        repeat (40) @(posedge CLK);
        #1;
        chk("same_drained", refresh_pending, 0);
        chk("same_queue_empty", exp_q.size(), 0);

        // Reset pulsed while port B is busy.
        auto_done = 1'b0;
        do_reset(1'b0, 1'b1);
        exp_q.push_back(SEL_PORT_B);
        repeat (395) @(posedge CLK);
        #1;
        chk("busy_b_gnt", b_gnt, 1);
        chk("busy_sel", ctl_sel, 1);
        chk("busy_pending", refresh_pending, 1);
        b_req = 1'b0;
        #3;
        RESET_n = 1'b0;
        #1;
        chk("async_b_gnt", b_gnt, 0);
        chk("async_start", ctl_start, 0);
        chk("async_pending", refresh_pending, 0);
        chk("async_sel", ctl_sel, 0);
        @(negedge CLK);
        RESET_n = 1'b1;
        @(posedge CLK);
        #1;
        s_done = 1'b1;
        @(posedge CLK);
        #1;
        s_done = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("stray_done_a", a_gnt, 0);
        chk("stray_done_b", b_gnt, 0);
        chk("stray_done_pending", refresh_pending, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
